spm_result_collector: RTL

SPM_RESULT_COLLECTOR -- requirements
Module: spm_result_collector

---
 rtl/npu_spm_defines.sv | 31 +++
 rtl/spm_result_collector.sv | 121 ++++++++++++
 2 files changed

// File: rtl/npu_spm_defines.sv
// -----------------------------------------------------------------------------
// npu_spm_defines
// Shared scratchpad (SPM) definitions: processing-element count, the per-lane
// data word type and the result-collector FSM state encoding.
// Contents:
//   `SM_PROCESSING_ELEMENTS  number of lanes served by the scratchpad
//   SM_PE                    the same count as a package localparam
//   sm_data_t                one lane's read word
//   spm_collector_state_t    IDLE / COLLECT / DONE
// -----------------------------------------------------------------------------
`ifndef NPU_SPM_DEFINES_SV
`define NPU_SPM_DEFINES_SV

`define SM_PROCESSING_ELEMENTS 16

package npu_spm_defines_pkg;

    localparam int SM_PE     = `SM_PROCESSING_ELEMENTS;
    localparam int SM_DATA_W = 32;

    typedef logic [SM_DATA_W-1:0] sm_data_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } spm_collector_state_t;

endpackage

`endif

// File: rtl/spm_result_collector.sv
// -----------------------------------------------------------------------------
// spm_result_collector
// Tracks one outstanding scratchpad request while the bank array serves its
// lanes over one or more cycles, gathers per-lane read words for loads and
// presents the completed result to the consumer.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only while IDLE)
//   req_is_store        request is a store: lanes are retired, no data kept
//   req_mask            participating lanes
//   serve_valid         bank array completed one service cycle
//   serve_mask          lanes served this cycle
//   serve_data          per-lane read words
//   pending_mask        lanes still awaiting service (to lane selection)
//   out_valid/ready     result handshake
//   out_mask            echo of the request mask
//   out_is_store        echo of the request type
//   out_data            gathered per-lane words (zero for unserved / store)
//   spurious_serve      one-cycle pulse: a served lane was not pending
// -----------------------------------------------------------------------------
module spm_result_collector
    import npu_spm_defines_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_store,
    input  logic [SM_PE-1:0]       req_mask,
    input  logic                   serve_valid,
    input  logic [SM_PE-1:0]       serve_mask,
    input  sm_data_t [SM_PE-1:0]   serve_data,
    output logic [SM_PE-1:0]       pending_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SM_PE-1:0]       out_mask,
    output logic                   out_is_store,
    output sm_data_t [SM_PE-1:0]   out_data,
    output logic                   spurious_serve
);

    spm_collector_state_t state, state_nx;

    logic [SM_PE-1:0]     pending_nx;
    logic [SM_PE-1:0]     out_mask_nx;
    logic                 out_is_store_nx;
    sm_data_t [SM_PE-1:0] out_data_nx;
    logic                 out_valid_nx;
    logic                 spurious_nx;

    // Lanes served now that were still owed vs. lanes served out of turn.
    logic [SM_PE-1:0] hit;
    logic [SM_PE-1:0] stray;

    assign hit   = serve_mask & pending_mask;
    assign stray = serve_mask & ~pending_mask;

    assign req_ready = (state == IDLE);

    always_comb begin
        state_nx        = state;
        pending_nx      = pending_mask;
        out_mask_nx     = out_mask;
        out_is_store_nx = out_is_store;
        out_data_nx     = out_data;
        spurious_nx     = 1'b0;

        case (state)
            IDLE: begin
                // No request owns the banks, so any served lane is stray.
                spurious_nx = serve_valid && (serve_mask != '0);
                if (req_valid) begin
                    pending_nx      = req_mask;
                    out_mask_nx     = req_mask;
                    out_is_store_nx = req_is_store;
                    out_data_nx     = '0;
                    state_nx        = (req_mask == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (serve_valid) begin
                    spurious_nx = (stray != '0);
                    pending_nx  = pending_mask & ~serve_mask;
                    for (int i = 0; i < SM_PE; i++) begin
                        if (hit[i] && !out_is_store) out_data_nx[i] = serve_data[i];
                    end
                    // Leave in the same update that retires the last lane.
                    if (pending_nx == '0) state_nx = DONE;
                end
            end
            DONE: begin
                spurious_nx = serve_valid && (serve_mask != '0);
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        out_valid_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pending_mask   <= '0;
            out_mask       <= '0;
            out_is_store   <= 1'b0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            spurious_serve <= 1'b0;
        end else begin
            state          <= state_nx;
            pending_mask   <= pending_nx;
            out_mask       <= out_mask_nx;
            out_is_store   <= out_is_store_nx;
            out_data       <= out_data_nx;
            out_valid      <= out_valid_nx;
            spurious_serve <= spurious_nx;
        end
    end

endmodule
